uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter.
- Accepts a byte on a valid strobe while idle and captures it with its parity bit.
- Drives the serial line through start, 8 data bits (LSB first), optional parity and stop, advancing one bit per baud tick.
- Sits between the host byte interface and the TX pin, and owns the busy flag seen by the byte source and the parity logic.

Parameters:
- PARITY_TYPE, 0, parity rule: 0 = XOR of data bits (even parity), 1 = XNOR of data bits (odd parity).
- DATA_W, 8, data bits per frame (must be ≥ 1; counter width = clog2(DATA_W)).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_tick  input  1  baud enable, one-cycle pulse per bit period.
- p_data  input  DATA_W  byte to send.
- data_valid  input  1  p_data is valid; sampled only in IDLE.
- par_en  input  1  include parity bit; sampled with the byte.
- tx_out  output  1  serial line.
- busy  output  1  frame in progress; byte source must hold off.
- mux_sel  output  2  bit source: 00 start, 01 data, 10 parity, 11 stop/idle.
- frame_done  output  1  one-cycle pulse on the stop-bit exit edge.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_out=1, busy=0, mux_sel=11, frame_done=0, bit counter=0, shift and parity registers=0, par_en latch=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - On a clk edge with data_valid=1, independent of tx_tick:
    - load the shift register with p_data;
    - latch par_en;
    - compute parity per PARITY_TYPE from p_data and register it;
    - go to START.
  - data_valid=0 keeps IDLE.
- Accept latency: byte accepted at edge k; tx_out=0 and busy=1 from cycle k+1.
- Tick rule: all transitions out of START, DATA, PARITY and STOP occur only on edges where tx_tick=1. One bit lasts from its entry edge to the next ticked edge. A tick in the same cycle as entry to START gives a 1-cycle start bit; meeting the bit-period timing is the baud generator's responsibility.
- START: tx_out=0, mux_sel=00. On tick go to DATA with counter=0.
- DATA:
  - tx_out=shift[0], mux_sel=01.
  - On tick, shift right and increment the counter.
  - At counter=DATA_W-1 with tick, go to PARITY if the latched par_en=1, else go to STOP.
- PARITY: tx_out=registered parity, mux_sel=10. On tick go to STOP.
- STOP:
  - tx_out=1, mux_sel=11.
  - On tick go to IDLE and pulse frame_done for exactly that one following cycle.
  - busy drops in the same cycle (first IDLE cycle).
- Back-to-back: a new byte may be accepted in the first IDLE cycle, giving a minimum one-cycle idle gap.
- data_valid while busy=1: ignored. p_data and par_en changes mid-frame have no effect.
- tx_tick in IDLE: ignored.
- Reset mid-frame: immediate return to the reset values above; the partial frame is abandoned and the line goes high asynchronously.
- All outputs registered; tx_out is glitch-free.
- Illegal state encodings recover to IDLE.
- Frame length in ticks: 1 + DATA_W + par_en + 1.

Decomposition:
- Shared uart package:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - mux_sel encodings MUX_START=2'b00, MUX_DATA=2'b01, MUX_PAR=2'b10, MUX_STOP=2'b11;
  - parity type constants PAR_EVEN=0, PAR_ODD=1.
- Sub-module uart_tx_shift holds the shift register and bit counter:
  - inputs: load, shift_en, data;
  - outputs: ser_bit, last_bit.
- The FSM, parity capture and output register stay in uart_tx_ctrl.

Test Plan:
- Even parity: PARITY_TYPE=0, tx_tick tied 1, p_data=0xA5, par_en=1, one-cycle data_valid. tx_out from k+1 = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles). busy high for 11 cycles. frame_done pulses in the first IDLE cycle.
- No parity, sparse tick: PARITY_TYPE=1, par_en=0, p_data=0x01, tx_tick every 4 cycles. Sequence start,1,0×7,stop (10 bits), each bit held 4 cycles except a possibly shorter start bit. Mux_sel never 10.
- Odd parity: PARITY_TYPE=1, p_data=0xA5, par_en=1. Parity bit=1. With PARITY_TYPE=0, p_data=0x01, the parity bit is 1.
- Busy blocking: data_valid=1 with p_data=0x3C during a 0xA5 frame. Transmitted byte stays 0xA5. Holding data_valid through the frame starts 0x3C exactly one IDLE cycle after frame_done.
- Async reset: assert rst=0 mid-DATA between clock edges. tx_out=1, busy=0, mux_sel=11 immediately. After release, a 0x55 frame transmits cleanly.
- Tick in IDLE: pulse tx_tick with data_valid=0 for 20 cycles. tx_out stays 1, busy stays 0, frame_done stays 0.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit path: frame sequencer states,
// bit-source select encodings and parity rule constants.
package uart_tx_ctrl_pkg;

    // Frame sequencer states. Encodings 5..7 are unused and fall back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Bit source select shown on mux_sel while the line carries that bit.
    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_DATA  = 2'b01;
    localparam logic [1:0] MUX_PAR   = 2'b10;
    localparam logic [1:0] MUX_STOP  = 2'b11;

    // Parity rules: even parity sends the XOR of the data bits, odd sends XNOR.
    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Turn the XOR reduction of the data bits into the transmitted parity bit.
    function automatic logic frame_parity(input logic data_xor, input int parity_type);
        return (parity_type == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// Data shift register and bit counter for the UART transmitter.
// ser_bit is look-ahead: it is the bit that sits in the serial position
// after the current clock edge, so the owner can register it straight into
// its output flop and keep tx_out aligned with the state change.
module uart_tx_shift
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] data,
    output logic              ser_bit,
    output logic              last_bit
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Load restarts the counter; each shift moves the next bit into position 0.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = data;
            cnt_d   = '0;
        end else if (shift_en) begin
            shift_d = shift_q >> 1;
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Shift and counter state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_bit  = shift_d[0];
    assign last_bit = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer. Accepts a byte while idle, then walks the
// line through start, DATA_W data bits (LSB first), optional parity and stop,
// advancing one bit on each baud tick. All outputs come straight from flops
// so tx_out is glitch-free.
//
// Handshake: the byte source presents p_data/par_en with data_valid. A byte
// is taken on any clock edge where the sequencer is idle (busy=0) and
// data_valid=1; data_valid while busy=1 is ignored and nothing is queued.
// busy rises the cycle after acceptance and falls together with the
// one-cycle frame_done pulse, so a held data_valid starts the next frame
// after exactly one idle cycle.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int PARITY_TYPE = 0,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_tick,
    input  logic [DATA_W-1:0] p_data,
    input  logic              data_valid,
    input  logic              par_en,
    output logic              tx_out,
    output logic              busy,
    output logic [1:0]        mux_sel,
    output logic              frame_done,
    output logic [2:0]        state_dbg
);

    state_e     state_q;
    state_e     state_d;
    logic       tx_q;
    logic       tx_d;
    logic       busy_q;
    logic       busy_d;
    logic [1:0] mux_q;
    logic [1:0] mux_d;
    logic       done_q;
    logic       done_d;
    logic       par_en_q;
    logic       par_en_d;
    logic       par_q;
    logic       par_d;

    logic       load;
    logic       shift_en;
    logic       ser_bit;
    logic       last_bit;

    uart_tx_shift #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .data     (p_data),
        .ser_bit  (ser_bit),
        .last_bit (last_bit)
    );

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so the registered line changes on the same edge.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        mux_d    = mux_q;
        done_d   = 1'b0;
        par_en_d = par_en_q;
        par_d    = par_q;
        load     = 1'b0;
        shift_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                mux_d  = MUX_STOP;
                if (data_valid) begin
                    load     = 1'b1;
                    par_en_d = par_en;
                    par_d    = frame_parity(^p_data, PARITY_TYPE);
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    mux_d    = MUX_START;
                end
            end

            ST_START: begin
                if (tx_tick) begin
                    state_d = ST_DATA;
                    tx_d    = ser_bit;
                    mux_d   = MUX_DATA;
                end
            end

            ST_DATA: begin
                if (tx_tick) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                            mux_d   = MUX_PAR;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                            mux_d   = MUX_STOP;
                        end
                    end else begin
                        tx_d = ser_bit;
                    end
                end
            end

            ST_PARITY: begin
                if (tx_tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    mux_d   = MUX_STOP;
                end
            end

            ST_STOP: begin
                if (tx_tick) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    mux_d   = MUX_STOP;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                mux_d   = MUX_STOP;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset drives the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            mux_q    <= MUX_STOP;
            done_q   <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            mux_q    <= mux_d;
            done_q   <= done_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
        end
    end

    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign mux_sel    = mux_q;
    assign frame_done = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl. Two instances share all inputs, one per parity
// rule. A driver issues bytes and records {par_en, data} in exp_q; a monitor
// collects the bit present on each ticked cycle of every frame and, on
// frame_done, rebuilds the expected frame from the byte with plain arithmetic.
module tb_uart_tx_ctrl;
    import uart_tx_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_tick;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;

    logic [1:0] tx_out_w;
    logic [1:0] busy_w;
    logic [1:0] fd_w;
    logic [1:0] mux_w [2];
    logic [2:0] dbg_w [2];

    int         checks = 0;
    int         fails  = 0;
    logic [8:0] exp_q[$];
    int         tick_mode = 0;
    int         cyc = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    uart_tx_ctrl #(.PARITY_TYPE(0), .DATA_W(8)) dut_even (
        .clk(clk), .rst(rst), .tx_tick(tx_tick), .p_data(p_data),
        .data_valid(data_valid), .par_en(par_en), .tx_out(tx_out_w[0]),
        .busy(busy_w[0]), .mux_sel(mux_w[0]), .frame_done(fd_w[0]),
        .state_dbg(dbg_w[0])
    );

    uart_tx_ctrl #(.PARITY_TYPE(1), .DATA_W(8)) dut_odd (
        .clk(clk), .rst(rst), .tx_tick(tx_tick), .p_data(p_data),
        .data_valid(data_valid), .par_en(par_en), .tx_out(tx_out_w[1]),
        .busy(busy_w[1]), .mux_sel(mux_w[1]), .frame_done(fd_w[1]),
        .state_dbg(dbg_w[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Baud tick source: 0 = every cycle, 1 = every 4th cycle, 2 = random.
    initial begin
        tx_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (tick_mode)
                0:       tx_tick = 1'b1;
                1:       tx_tick = ((cyc % 4) == 0);
                default: tx_tick = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Reference frame: start 0, data LSB first, optional parity, stop 1.
    task automatic model(input logic [8:0] e, input int ptype,
                         output logic [15:0] bits, output int len, output logic [31:0] mux);
        int ones;
        bits = '0;
        mux  = '0;
        len  = 0;
        bits[len] = 1'b0; mux[2*len +: 2] = 2'b00; len++;
        for (int i = 0; i < 8; i++) begin
            bits[len] = e[i]; mux[2*len +: 2] = 2'b01; len++;
        end
        if (e[8]) begin
            ones = $countones(e[7:0]);
            // even rule: total ones including parity is even; odd rule: odd
            bits[len] = (ptype == 0) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            mux[2*len +: 2] = 2'b10;
            len++;
        end
        bits[len] = 1'b1; mux[2*len +: 2] = 2'b11; len++;
    endtask

    // Monitor / scoreboard
    logic [15:0] got_bits [2];
    logic [31:0] got_mux  [2];
    int          got_len  [2];
    logic        prev_busy[2];
    logic        prev_tx  [2];
    logic [1:0]  prev_mux [2];
    logic        prev_tick;

    initial begin
        logic [8:0]  e;
        logic [15:0] eb;
        logic [31:0] em;
        int          el;
        for (int i = 0; i < 2; i++) begin
            got_bits[i] = '0; got_mux[i] = '0; got_len[i] = 0;
            prev_busy[i] = 1'b0; prev_tx[i] = 1'b1; prev_mux[i] = 2'b11;
        end
        prev_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    got_bits[i] = '0; got_mux[i] = '0; got_len[i] = 0;
                    prev_busy[i] = 1'b0;
                end
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                if (busy_w[i] && prev_busy[i] && !prev_tick) begin
                    chk($sformatf("hold_tx_d%0d", i), 32'(tx_out_w[i]), 32'(prev_tx[i]));
                    chk($sformatf("hold_mux_d%0d", i), 32'(mux_w[i]), 32'(prev_mux[i]));
                end
                if (busy_w[i] && tx_tick && got_len[i] < 16) begin
                    got_bits[i][got_len[i]] = tx_out_w[i];
                    got_mux[i][2*got_len[i] +: 2] = mux_w[i];
                    got_len[i]++;
                end
                if (!busy_w[i]) begin
                    chk($sformatf("idle_line_d%0d", i), 32'(tx_out_w[i]), 32'd1);
                end
                prev_busy[i] = busy_w[i];
                prev_tx[i]   = tx_out_w[i];
                prev_mux[i]  = mux_w[i];
            end
            prev_tick = tx_tick;
            if (fd_w != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_done", 32'(fd_w), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < 2; i++) begin
                        model(e, i, eb, el, em);
                        chk($sformatf("frame_done_d%0d_%0h", i, e), 32'(fd_w[i]), 32'd1);
                        chk($sformatf("frame_len_d%0d_%0h", i, e), 32'(got_len[i]), 32'(el));
                        chk($sformatf("frame_bits_d%0d_%0h", i, e), 32'(got_bits[i]), 32'(eb));
                        chk($sformatf("frame_mux_d%0d_%0h", i, e), got_mux[i], em);
                        chk($sformatf("busy_at_done_d%0d", i), 32'(busy_w[i]), 32'd0);
                        got_bits[i] = '0; got_mux[i] = '0; got_len[i] = 0;
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic wait_idle();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (busy_w == 2'b00) return;
        end
        chk("wait_idle_timeout", 32'(busy_w), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pe);
        wait_idle();
        p_data     = d;
        par_en     = pe;
        data_valid = 1'b1;
        exp_q.push_back({pe, d});
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        p_data     = 8'($urandom);
        par_en     = 1'($urandom);
        @(negedge clk);
        chk("accept_tx_low", 32'(tx_out_w), 32'd0);
        chk("accept_busy", 32'(busy_w), 32'h3);
    endtask

    task automatic busy_length(output int n);
        n = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy_w[0]) n++;
            else break;
        end
    endtask

    // Stimulus sequence
    initial begin
        int n;
        rst        = 1'b0;
        data_valid = 1'b0;
        p_data     = '0;
        par_en     = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_tx_d%0d", i), 32'(tx_out_w[i]), 32'd1);
            chk($sformatf("rst_busy_d%0d", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("rst_mux_d%0d", i), 32'(mux_w[i]), 32'h3);
            chk($sformatf("rst_done_d%0d", i), 32'(fd_w[i]), 32'd0);
            chk($sformatf("rst_state_d%0d", i), 32'(dbg_w[i]), 32'(ST_IDLE));
        end
        rst = 1'b1;

        // Back-to-back ticks, 0xA5 with parity
        tick_mode = 0;
        send_byte(8'hA5, 1'b1);
        busy_length(n);
        chk("busy_len_a5", 32'(n), 32'd11);
        chk("done_first_idle", 32'(fd_w), 32'h3);

        // Sparse tick, no parity
        tick_mode = 1;
        send_byte(8'h01, 1'b0);
        busy_length(n);
        chk("busy_len_sparse_in_range", 32'(n >= 37 && n <= 40), 32'd1);

        // Parity bits under both rules
        tick_mode = 0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);

        // Requests while busy are ignored; a held request starts after one idle cycle
        send_byte(8'hA5, 1'b1);
        p_data     = 8'h3C;
        par_en     = 1'b0;
        data_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (fd_w[0]) begin n = 1; break; end
        end
        chk("hold_valid_done_seen", 32'(n), 32'd1);
        exp_q.push_back({1'b0, 8'h3C});
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(negedge clk);
        chk("b2b_start_tx", 32'(tx_out_w), 32'd0);
        chk("b2b_start_busy", 32'(busy_w), 32'h3);

        // Asynchronous reset in the middle of the data bits
        tick_mode = 1;
        send_byte(8'hC3, 1'b1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx_out_w), 32'h3);
        chk("async_rst_busy", 32'(busy_w), 32'd0);
        chk("async_rst_mux0", 32'(mux_w[0]), 32'h3);
        chk("async_rst_mux1", 32'(mux_w[1]), 32'h3);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick_mode = 0;
        send_byte(8'h55, 1'($urandom_range(0, 1)));
        wait_idle();

        // Ticks while idle do nothing
        tick_mode = 2;
        repeat (20) begin
            @(negedge clk);
            chk("idle_tick_tx", 32'(tx_out_w), 32'h3);
            chk("idle_tick_busy", 32'(busy_w), 32'd0);
            chk("idle_tick_done", 32'(fd_w), 32'd0);
        end

        // Randomized frames
        for (int k = 0; k < 30; k++) begin
            tick_mode = $urandom_range(0, 2);
            send_byte(8'($urandom), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
